// File: rtl/sram_access_sequencer.sv
// sram_access_sequencer: cycle-timed single-word read/write sequencer for an async 16x256K SRAM pin driver
module sram_access_sequencer #(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2,
  parameter int TURN_CYC   = 1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [17:0] iADDR,
  input  logic [15:0] iWDATA,
  input  logic [1:0]  iBYTEEN,
  input  logic        iREAD,
  input  logic        iWRITE,
  output logic        oWAITREQ,
  output logic [15:0] oRDATA,
  output logic        oRDVALID,
  output logic [17:0] oSRAM_ADDR,
  output logic [15:0] oSRAM_WDATA,
  input  logic [15:0] iSRAM_RDATA,
  output logic        oSRAM_CE_N,
  output logic        oSRAM_OE_N,
  output logic        oSRAM_WE_N,
  output logic [1:0]  oSRAM_BE_N
);
  localparam logic [2:0] S_IDLE = 3'd0, S_RD = 3'd1, S_WS = 3'd2, S_WP = 3'd3, S_WH = 3'd4, S_TURN = 3'd5;
  localparam logic [3:0] RW = 4'(READ_WAIT - 1);
  localparam logic [3:0] WW = 4'(WRITE_WAIT - 1);
  localparam logic [3:0] TC = 4'(TURN_CYC - 1);
  localparam logic [2:0] AFTER = (TURN_CYC == 0) ? S_IDLE : S_TURN;
  if (READ_WAIT < 1 || READ_WAIT > 15 || WRITE_WAIT < 1 || WRITE_WAIT > 15 || TURN_CYC < 0 || TURN_CYC > 15) begin : g_bad_param
    $error("sram_access_sequencer: parameter out of range");
  end
  logic [2:0]  r_state, w_next;
  logic [3:0]  r_cnt, w_cnt;
  logic        w_tc, w_acc, w_ce_n, w_cap;
  logic        r_ce_n, r_oe_n, r_we_n, r_rdvalid;
  logic [1:0]  r_be_n;
  logic [17:0] r_addr;
  logic [15:0] r_wdata, r_rdata;
  assign w_tc   = r_cnt == 4'd0;
  assign w_acc  = r_state == S_IDLE && (iREAD || iWRITE);
  assign w_cap  = r_state == S_RD && w_tc;
  assign w_ce_n = w_next == S_IDLE || w_next == S_TURN;
  // Counter holds remaining cycles minus one in the current state; zero means last cycle.
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt - 4'd1;
    case (r_state)
      S_IDLE: begin
        w_next = iWRITE ? S_WS : iREAD ? S_RD : S_IDLE;
        w_cnt  = (!iWRITE && iREAD) ? RW : 4'd0;
      end
      S_RD: if (w_tc) begin
        w_next = AFTER;
        w_cnt  = TC;
      end
      S_WS: begin
        w_next = S_WP;
        w_cnt  = WW;
      end
      S_WP: if (w_tc) begin
        w_next = S_WH;
        w_cnt  = 4'd0;
      end
      S_WH: begin
        w_next = AFTER;
        w_cnt  = TC;
      end
      S_TURN: if (w_tc) begin
        w_next = S_IDLE;
        w_cnt  = 4'd0;
      end
      default: begin
        w_next = S_IDLE;
        w_cnt  = 4'd0;
      end
    endcase
  end
  // Strobes are registered from the next state so they match the state during its cycles.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_ce_n    <= 1'b1;
      r_oe_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_be_n    <= 2'b11;
      r_addr    <= 18'd0;
      r_wdata   <= 16'd0;
      r_rdata   <= 16'd0;
      r_rdvalid <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt;
      r_ce_n    <= w_ce_n;
      r_oe_n    <= w_next != S_RD;
      r_we_n    <= w_next != S_WP;
      r_rdvalid <= w_cap;
      if (w_cap) r_rdata <= iSRAM_RDATA;
      if (w_acc) begin
        r_addr  <= iADDR;
        r_wdata <= iWDATA;
        r_be_n  <= ~iBYTEEN;
      end else if (w_ce_n) r_be_n <= 2'b11;
    end
  end
  assign oWAITREQ    = iRST || r_state != S_IDLE;
  assign oRDATA      = r_rdata;
  assign oRDVALID    = r_rdvalid;
  assign oSRAM_ADDR  = r_addr;
  assign oSRAM_WDATA = r_wdata;
  assign oSRAM_CE_N  = r_ce_n;
  assign oSRAM_OE_N  = r_oe_n;
  assign oSRAM_WE_N  = r_we_n;
  assign oSRAM_BE_N  = r_be_n;
endmodule
